// File: rtl/ww_console_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ww_console_pkg
//  Description : Shared encodings, state enum and default widths for the
//                Whirlwind console sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package ww_console_pkg;

  // Default widths and sizes
  localparam int WORD_W_DEF = 16;
  localparam int ADDR_W_DEF = 11;
  localparam int TS_N_DEF   = 32;
  localparam int FF_N_DEF   = 5;
  localparam int TMO_W_DEF  = 24;

  // Host command / switch-bank kind encodings
  localparam logic [1:0] K_PC = 2'd0;
  localparam logic [1:0] K_TS = 2'd1;
  localparam logic [1:0] K_FF = 2'd2;
  localparam logic [1:0] K_GO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SWRST  = 3'd2,
    S_SETTLE = 3'd3,
    S_OSC    = 3'd4,
    S_STRST  = 3'd5,
    S_RUN    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  // Largest of three pulse lengths, used to size the shared timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // A switch write lands only when its index exists in the selected bank
  function automatic logic idx_ok(input logic [1:0] kind, input int idx,
                                  input int ts_n, input int ff_n);
    logic ok;
    case (kind)
      K_PC:    ok = 1'b1;
      K_TS:    ok = (idx < ts_n);
      K_FF:    ok = (idx < ff_n);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ww_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ww_pulse_timer
//  Description : Loadable down-counter with zero flag. Loading N-1 makes the
//                zero flag appear on the Nth cycle after the load edge.
//  Revision    : 1.0  initial release
// ============================================================================
module ww_pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Count down to zero and hold there until reloaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ww_console_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ww_console_seq
//  Description : Console sequencer for the Whirlwind core. Loads PC/TS/FF
//                switches one command at a time and, on GO, runs the panel
//                start sequence (sw_reset, settle, oscillator on,
//                storage_reset), then runs until halt or timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module ww_console_seq
  import ww_console_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int TS_N     = TS_N_DEF,
  parameter int FF_N     = FF_N_DEF,
  parameter int RST_CYC  = 5,
  parameter int SETL_CYC = 5,
  parameter int STOR_CYC = 10,
  parameter int TMO_W    = TMO_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WORD_W-1:0] cmd_data,
  output logic              sw_we,
  output logic [1:0]        sw_kind,
  output logic [ADDR_W-1:0] sw_idx,
  output logic [WORD_W-1:0] sw_data,
  output logic              sw_reset,
  output logic              sw_enable_osc,
  output logic              storage_reset,
  input  logic              halt,
  output logic              done,
  output logic              timed_out,
  output logic [TMO_W-1:0]  run_cycles
);

  localparam int TMR_MAX = max3(RST_CYC, SETL_CYC, STOR_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t             r_state;
  logic               r_cmd_ready;
  logic               r_sw_we;
  logic [1:0]         r_sw_kind;
  logic [ADDR_W-1:0]  r_sw_idx;
  logic [WORD_W-1:0]  r_sw_data;
  logic               r_sw_reset;
  logic               r_osc;
  logic               r_stor_reset;
  logic               r_done;
  logic               r_timed_out;
  logic [TMO_W-1:0]   r_run_cycles;
  logic [TMO_W-1:0]   r_tmo;

  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_zero;
  logic [TMO_W-1:0]   w_cnt_nxt;

  // One shared timer times every fixed-length phase of the start sequence
  ww_pulse_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // Reload the timer on entry to SWRST, SETTLE and STRST
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && (cmd_kind == K_GO)) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(RST_CYC - 1);
        end
      end
      S_SWRST: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(SETL_CYC - 1);
        end
      end
      S_OSC: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = TMR_W'(STOR_CYC - 1);
      end
      default: ;
    endcase
  end

  // Run counter saturates rather than wrapping
  assign w_cnt_nxt = (&r_run_cycles) ? r_run_cycles : (r_run_cycles + TMO_W'(1));

  // Sequencer FSM with all panel outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b1;
      r_sw_we      <= 1'b0;
      r_sw_kind    <= '0;
      r_sw_idx     <= '0;
      r_sw_data    <= '0;
      r_sw_reset   <= 1'b0;
      r_osc        <= 1'b0;
      r_stor_reset <= 1'b0;
      r_done       <= 1'b0;
      r_timed_out  <= 1'b0;
      r_run_cycles <= '0;
      r_tmo        <= '0;
    end else begin
      r_sw_we <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // cmd_ready is high throughout IDLE, so valid alone means accept
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            if (cmd_kind == K_GO) begin
              r_tmo        <= TMO_W'(cmd_data);
              r_timed_out  <= 1'b0;
              r_run_cycles <= '0;
              r_sw_reset   <= 1'b1;
              r_state      <= S_SWRST;
            end else begin
              r_sw_we   <= idx_ok(cmd_kind, int'(cmd_addr), TS_N, FF_N);
              r_sw_kind <= cmd_kind;
              r_sw_idx  <= (cmd_kind == K_PC) ? '0 : cmd_addr;
              r_sw_data <= cmd_data;
              r_state   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_SWRST: begin
          if (w_tmr_zero) begin
            r_sw_reset <= 1'b0;
            r_state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_tmr_zero) begin
            r_osc   <= 1'b1;
            r_state <= S_OSC;
          end
        end
        S_OSC: begin
          r_stor_reset <= 1'b1;
          r_state      <= S_STRST;
        end
        S_STRST: begin
          if (w_tmr_zero) begin
            r_stor_reset <= 1'b0;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          r_run_cycles <= w_cnt_nxt;
          // halt takes priority over a coincident timeout
          if (halt) begin
            r_timed_out <= 1'b0;
            r_done      <= 1'b1;
            r_osc       <= 1'b0;
            r_state     <= S_DONE;
          end else if ((r_tmo != '0) && (w_cnt_nxt == r_tmo)) begin
            r_timed_out <= 1'b1;
            r_done      <= 1'b1;
            r_osc       <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign sw_we         = r_sw_we;
  assign sw_kind       = r_sw_kind;
  assign sw_idx        = r_sw_idx;
  assign sw_data       = r_sw_data;
  assign sw_reset      = r_sw_reset;
  assign sw_enable_osc = r_osc;
  assign storage_reset = r_stor_reset;
  assign done          = r_done;
  assign timed_out     = r_timed_out;
  assign run_cycles    = r_run_cycles;

endmodule
`default_nettype wire
